// File: rtl/match_pkg.sv
// Shared types and constants for the match arbiter controller.
package match_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int          PIPE_DEPTH_DEF = 3;
   localparam logic [7:0]  PATTERN_RST    = 8'hEF;
   localparam logic [31:0] CNT_MAX        = 32'hFFFF_FFFF;

   // Saturating increment for the match counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + 32'd1;
   endfunction

endpackage

// File: rtl/match_pipe.sv
// Fixed-latency compare pipeline: the byte is compared against the pattern
// on entry to stage 1, and only valid/id/match travel down the remaining stages.
module match_pipe
   import match_pkg::*;
#(
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       acc_valid,
   input  logic       acc_id,
   input  logic [7:0] acc_byte,
   input  logic [7:0] pattern,
   output logic       ret_valid,
   output logic       ret_id,
   output logic       ret_match,
   output logic       in_flight
);

   logic [PIPE_DEPTH-1:0] v_q;
   logic [PIPE_DEPTH-1:0] id_q;
   logic [PIPE_DEPTH-1:0] m_q;

   // Shift register; id/match are zeroed for empty slots so idle outputs read 0.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         v_q  <= '0;
         id_q <= '0;
         m_q  <= '0;
      end else begin
         v_q[0]  <= acc_valid;
         id_q[0] <= acc_valid & acc_id;
         m_q[0]  <= acc_valid & (acc_byte == pattern);
         for (int s = 1; s < PIPE_DEPTH; s++) begin
            v_q[s]  <= v_q[s-1];
            id_q[s] <= id_q[s-1];
            m_q[s]  <= m_q[s-1];
         end
      end
   end

   assign ret_valid = v_q[PIPE_DEPTH-1];
   assign ret_id    = id_q[PIPE_DEPTH-1];
   assign ret_match = m_q[PIPE_DEPTH-1];
   assign in_flight = |v_q;

endmodule

// File: rtl/match_arbiter_ctrl.sv
// Two-requester round-robin arbiter feeding a byte-match pipeline, with
// per-requester saturating match counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | stopped; pattern may be loaded
// ST_RUN   | grants issued round-robin while en is high
// ST_DRAIN | en dropped; no grants, in-flight items retire, then IDLE
module match_arbiter_ctrl
   import match_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              en,
   input  logic              cfg_load,
   input  logic [7:0]        cfg_pattern,
   input  logic              cnt_clr,
   input  logic              req0_valid,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req0_ready,
   output logic              req1_ready,
   output logic              valid_out,
   output logic              out_id,
   output logic              out_match,
   output logic [31:0]       match_cnt0,
   output logic [31:0]       match_cnt1,
   output logic              busy
);

   state_t      state;
   logic        prio1;
   logic [7:0]  pattern;
   logic        gnt0;
   logic        gnt1;
   logic        run_gnt;
   logic        xfer;
   logic [7:0]  acc_byte;
   logic        in_flight;
   logic [31:0] cnt0_nxt;
   logic [31:0] cnt1_nxt;
   logic        unused_hi;

   // Only the low byte takes part in the compare.
   assign unused_hi = ^{req0_data[DATA_W-1:8], req1_data[DATA_W-1:8]};

   // Grant: prio1 set means req0 won the last transfer, so req1 goes first on a tie.
   always_comb begin
      run_gnt = (state == ST_RUN) && en && !i_reset;
      gnt0    = run_gnt && req0_valid && (!req1_valid || !prio1);
      gnt1    = run_gnt && req1_valid && (!req0_valid || prio1);
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign xfer       = gnt0 | gnt1;
   assign acc_byte   = gnt1 ? req1_data[7:0] : req0_data[7:0];

   match_pipe #(
      .PIPE_DEPTH (PIPE_DEPTH)
   ) u_pipe (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .acc_valid (xfer),
      .acc_id    (gnt1),
      .acc_byte  (acc_byte),
      .pattern   (pattern),
      .ret_valid (valid_out),
      .ret_id    (out_id),
      .ret_match (out_match),
      .in_flight (in_flight)
   );

   // Run/drain sequencing; busy is registered alongside the state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!en) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (en) begin
                  state <= ST_RUN;
               end else if (!in_flight) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Round-robin pointer moves only when a transfer completes.
   always_ff @(posedge i_clk) begin
      if (i_reset)   prio1 <= 1'b0;
      else if (xfer) prio1 <= gnt0;
   end

   // Pattern is writable only while stopped so in-flight compares stay coherent.
   always_ff @(posedge i_clk) begin
      if (i_reset)                            pattern <= PATTERN_RST;
      else if (cfg_load && state == ST_IDLE) pattern <= cfg_pattern;
   end

   // Clear wins over a coincident increment.
   always_comb begin
      cnt0_nxt = match_cnt0;
      cnt1_nxt = match_cnt1;
      if (cnt_clr) begin
         cnt0_nxt = '0;
         cnt1_nxt = '0;
      end else if (valid_out && out_match) begin
         if (out_id) cnt1_nxt = sat_inc(match_cnt1);
         else        cnt0_nxt = sat_inc(match_cnt0);
      end
   end

   // Counter registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         match_cnt0 <= '0;
         match_cnt1 <= '0;
      end else begin
         match_cnt0 <= cnt0_nxt;
         match_cnt1 <= cnt1_nxt;
      end
   end

endmodule

// File: tb/tb_match_arbiter_ctrl.sv
// Bench for match_arbiter_ctrl: directed scenarios plus random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_match_arbiter_ctrl;

   localparam int DATA_W = 32;
   localparam int PD     = 3;

   logic              i_clk = 1'b0;
   logic              i_reset = 1'b1;
   logic              en = 1'b0;
   logic              cfg_load = 1'b0;
   logic [7:0]        cfg_pattern = 8'h00;
   logic              cnt_clr = 1'b0;
   logic              req0_valid = 1'b0;
   logic              req1_valid = 1'b0;
   logic [DATA_W-1:0] req0_data = '0;
   logic [DATA_W-1:0] req1_data = '0;
   logic              req0_ready, req1_ready, valid_out, out_id, out_match, busy;
   logic [31:0]       match_cnt0, match_cnt1;

   match_arbiter_ctrl #(.DATA_W(DATA_W), .PIPE_DEPTH(PD)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .en          (en),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cnt_clr     (cnt_clr),
      .req0_valid  (req0_valid),
      .req1_valid  (req1_valid),
      .req0_data   (req0_data),
      .req1_data   (req1_data),
      .req0_ready  (req0_ready),
      .req1_ready  (req1_ready),
      .valid_out   (valid_out),
      .out_id      (out_id),
      .out_match   (out_match),
      .match_cnt0  (match_cnt0),
      .match_cnt1  (match_cnt1),
      .busy        (busy)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int vo_cnt  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int due;
      bit id;
      bit m;
   } item_t;

   item_t       q[$];
   int          m_st   = 0;      // 0 idle, 1 run, 2 drain
   int          m_last = 1;      // index granted last; 1 means req0 goes first
   logic [7:0]  m_pat  = 8'hEF;
   logic [31:0] m_cnt [2] = '{32'd0, 32'd0};
   int          cyc    = 0;

   always @(negedge i_clk) begin
      int    g;
      bit    e_vo, e_id, e_m, infl;
      item_t it;
      g = -1;
      if (m_st == 1 && en && !i_reset) begin
         if (req0_valid && req1_valid) g = 1 - m_last;
         else if (req0_valid)          g = 0;
         else if (req1_valid)          g = 1;
      end
      e_vo = (q.size() > 0) && (q[0].due == cyc);
      e_id = e_vo ? q[0].id : 1'b0;
      e_m  = e_vo ? q[0].m  : 1'b0;

      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("valid_out",  valid_out,  e_vo);
      chk("out_id",     out_id,     e_id);
      chk("out_match",  out_match,  e_m);
      chk("busy",       busy,       m_st != 0);
      chk("match_cnt0", match_cnt0, m_cnt[0]);
      chk("match_cnt1", match_cnt1, m_cnt[1]);

      if (i_reset) begin
         m_st = 0; m_last = 1; m_pat = 8'hEF; q.delete();
         m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
         infl = q.size() > 0;
         if (cnt_clr) begin
            m_cnt[0] = 0; m_cnt[1] = 0;
         end else if (e_vo && e_m) begin
            if (m_cnt[e_id] != 32'hFFFF_FFFF) m_cnt[e_id] = m_cnt[e_id] + 1;
         end
         if (g >= 0) begin
            it.due = cyc + PD;
            it.id  = g[0];
            it.m   = ((g == 0) ? req0_data[7:0] : req1_data[7:0]) == m_pat;
            q.push_back(it);
            m_last = g;
         end
         if (cfg_load && m_st == 0) m_pat = cfg_pattern;
         if (e_vo) void'(q.pop_front());
         case (m_st)
            0:       if (en) m_st = 1;
            1:       if (!en) m_st = 2;
            default: if (en) m_st = 1; else if (!infl) m_st = 0;
         endcase
      end
      cyc++;
   end

   always @(negedge i_clk) if (valid_out) vo_cnt++;

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      i_reset = 1'b1; en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(2);
      i_reset = 1'b0;
   endtask

   task automatic send(input bit id, input logic [7:0] b);
      logic [DATA_W-1:0] d;
      bit done;
      done = 1'b0;
      d = $urandom();
      d[7:0] = b;
      if (id) begin req1_valid = 1'b1; req1_data = d; end
      else    begin req0_valid = 1'b1; req0_data = d; end
      for (int k = 0; k < 50 && !done; k++) begin
         #1;
         done = id ? req1_ready : req0_ready;
         step();
      end
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_vo();
      int k;
      k = 0;
      while (!valid_out && k < 20) begin step(); k++; end
      if (!valid_out) chk("wait_vo_timeout", 0, 1);
   endtask

   function automatic logic [7:0] pick_byte();
      case ($urandom_range(0, 3))
         0:       return 8'hEF;
         1:       return 8'h55;
         2:       return 8'hA5;
         default: return 8'($urandom());
      endcase
   endfunction

   // ---------------- scenarios ----------------
   initial begin
      int base, k, g;
      logic [DATA_W-1:0] d;

      // Single requester, latency, no false matches.
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_valid_out", valid_out, 0);
      en = 1'b1;
      step();
      base = vo_cnt;
      for (int i = 0; i < 20; i++) send(1'b0, 8'(i));
      step(6);
      chk("t1_pulses", vo_cnt - base, 20);
      chk("t1_cnt0_zero", match_cnt0, 0);
      send(1'b0, 8'hEF);
      k = 0;
      while (!valid_out && k < 10) begin step(); k++; end
      chk("t1_latency", k + 1, 3);
      step(2);
      chk("t1_cnt0_one", match_cnt0, 1);

      // Contention: alternate starting at req0.
      do_reset();
      en = 1'b1;
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d = $urandom(); d[7:0] = 8'hEF; req0_data = d;
         d = $urandom(); d[7:0] = 8'hEF; req1_data = d;
         #1;
         g = req1_ready ? 1 : (req0_ready ? 0 : -1);
         chk("t2_grant", g, i % 2);
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(5);
      chk("t2_cnt0", match_cnt0, 5);
      chk("t2_cnt1", match_cnt1, 5);

      // Drain with three items in flight.
      send(1'b0, 8'h10); send(1'b0, 8'h11); send(1'b0, 8'h12);
      base = vo_cnt;
      en = 1'b0;
      req0_valid = 1'b1; req0_data = 32'h0000_0013;
      #1;
      chk("t3_ready_off", req0_ready, 0);
      step();
      chk("t3_busy_drain", busy, 1);
      #1;
      chk("t3_ready_drain", req0_ready, 0);
      k = 0;
      while (busy && k < 10) begin step(); k++; end
      req0_valid = 1'b0;
      chk("t3_idle", busy, 0);
      chk("t3_pulses", vo_cnt - base, 3);

      // Config ignored in RUN, accepted in IDLE.
      en = 1'b1;
      step();
      cfg_load = 1'b1; cfg_pattern = 8'h55;
      step();
      cfg_load = 1'b0;
      send(1'b1, 8'h55);
      step(5);
      chk("t4_run_load_ignored", match_cnt1, 5);
      send(1'b1, 8'hEF);
      step(5);
      chk("t4_old_pattern", match_cnt1, 6);
      en = 1'b0;
      step(8);
      cfg_load = 1'b1; cfg_pattern = 8'h55;
      step();
      cfg_load = 1'b0;
      en = 1'b1;
      step();
      send(1'b1, 8'h55); send(1'b1, 8'hEF);
      step(5);
      chk("t4_idle_load", match_cnt1, 7);

      // Clear coincident with a match, then saturation.
      send(1'b0, 8'h55);
      wait_vo();
      chk("t5_vo_match", out_match, 1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("t5_clr_cnt0", match_cnt0, 0);
      chk("t5_clr_cnt1", match_cnt1, 0);
      force dut.match_cnt0 = 32'hFFFF_FFFF;
      m_cnt[0] = 32'hFFFF_FFFF;
      send(1'b0, 8'h55);
      wait_vo();
      step(2);
      release dut.match_cnt0;
      step();
      chk("t5_sat_hold", match_cnt0, 32'hFFFF_FFFF);
      send(1'b0, 8'h55);
      step(5);
      chk("t5_sat_again", match_cnt0, 32'hFFFF_FFFF);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;

      // Reset mid-stream.
      send(1'b1, 8'h55);
      step(4);
      chk("t6_pre_cnt1", match_cnt1, 1);
      send(1'b0, 8'h55); send(1'b1, 8'h55);
      i_reset = 1'b1; cfg_load = 1'b1; cfg_pattern = 8'h33; cnt_clr = 1'b0;
      step();
      i_reset = 1'b0; cfg_load = 1'b0; en = 1'b0;
      base = vo_cnt;
      step(6);
      chk("t6_no_pulses", vo_cnt - base, 0);
      chk("t6_cnt0", match_cnt0, 0);
      chk("t6_cnt1", match_cnt1, 0);
      chk("t6_busy", busy, 0);
      en = 1'b1;
      step();
      send(1'b0, 8'hEF); send(1'b0, 8'h33);
      step(5);
      chk("t6_pattern_rst", match_cnt0, 1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         d = $urandom(); d[7:0] = pick_byte(); req0_data = d;
         d = $urandom(); d[7:0] = pick_byte(); req1_data = d;
         cfg_load = ($urandom_range(0, 19) == 0);
         cfg_pattern = pick_byte();
         cnt_clr = ($urandom_range(0, 49) == 0);
         i_reset = ($urandom_range(0, 299) == 0);
         step();
      end
      i_reset = 1'b0; en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(10);
      chk("end_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/match_arbiter_ctrl.md
MATCH_ARBITER_CTRL -- requirements
Module: match_arbiter_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of request data.
REQ-002 SHALL have parameter PIPE_DEPTH, default 3, compare-pipeline latency in cycles.
REQ-003 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, run enable: grants are issued only while high.
REQ-006 SHALL have port cfg_load, input, 1, loads cfg_pattern into the pattern register.
REQ-007 SHALL have port cfg_pattern, input, 8, match byte compared against data[7:0].
REQ-008 SHALL have port cnt_clr, input, 1, clears both match counters.
REQ-009 SHALL have ports req0_valid/req1_valid, input, 1, requester has data.
REQ-010 SHALL have ports req0_data/req1_data, input, DATA_W, requester data.
REQ-011 SHALL have ports req0_ready/req1_ready, output, 1, grant; transfer = valid && ready.
REQ-012 SHALL have port valid_out, output, 1, one-cycle pulse per retired item.
REQ-013 SHALL have port out_id, output, 1, requester index of the retired item.
REQ-014 SHALL have port out_match, output, 1, retired item's data[7:0] equalled the pattern.
REQ-015 SHALL have ports match_cnt0/match_cnt1, output, 32, per-requester match counts.
REQ-016 SHALL have port busy, output, 1, high when state is not IDLE.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN on en; RUN->DRAIN on !en; DRAIN->IDLE when no item is in flight; DRAIN->RUN on en.
REQ-018 SHALL assert at most one reqN_ready per cycle, only in RUN, only to a requester whose valid is high (ready is combinational from valids, state and pointer).
REQ-019 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; after reset, req0 has priority.
REQ-020 SHALL update the last-grant pointer only on a completed transfer.
REQ-021 SHALL present an item accepted at cycle N on valid_out/out_id/out_match at cycle N+PIPE_DEPTH; output has no backpressure.
REQ-022 SHALL sustain one accepted item per cycle in RUN; outputs are registered.
REQ-023 SHALL compare data[7:0] == pattern register value captured in stage 1 of the pipeline.
REQ-024 SHALL accept cfg_load only in IDLE; in RUN or DRAIN cfg_load is ignored and the pattern is unchanged.
REQ-025 SHALL increment match_cnt[out_id] by 1 in the cycle after valid_out && out_match; counters saturate at 32'hFFFF_FFFF.
REQ-026 SHALL give cnt_clr priority over a coincident increment: both counters read 0 in the following cycle.
REQ-027 SHALL let in-flight items retire normally when en falls; no new grants in DRAIN.
REQ-028 SHALL drop all in-flight items on i_reset; no valid_out pulse for them.

Reset
REQ-029 SHALL, on i_reset, set state IDLE, pointer to favour req0, pattern 8'hEF, pipeline valids 0, counters 0.
REQ-030 SHALL drive reqN_ready=0, valid_out=0, out_id=0, out_match=0, busy=0 during and after reset until en.
REQ-031 SHALL apply reset mid-operation within one clock, overriding en, cfg_load and cnt_clr.

Structure
REQ-032 SHALL place the FSM state enum, PIPE_DEPTH default and pattern reset value 8'hEF in shared package match_pkg.
REQ-033 SHALL instantiate one sub-module match_pipe: PIPE_DEPTH-stage valid/id/data shift register with compare in stage 1.
REQ-034 SHALL keep arbitration, FSM and counters in match_arbiter_ctrl; target 150-300 RTL lines total.

Verification
REQ-035 SHALL test single requester: req0 sends 0x00..0x13 continuously under en -> 20 valid_out pulses, latency 3, match_cnt0=0 (no 0xEF), then send 0xEF -> match_cnt0=1.
REQ-036 SHALL test contention: both valid continuously with data 0xEF -> grants alternate 0,1,0,1 starting at req0; after 10 transfers match_cnt0=5, match_cnt1=5.
REQ-037 SHALL test drain: drop en with 3 items in flight -> state DRAIN, ready=0, 3 more valid_out pulses, then IDLE and busy=0.
REQ-038 SHALL test config: cfg_load 8'h55 in RUN -> ignored (0x55 not counted); in IDLE -> 0x55 counts.
REQ-039 SHALL test clear and saturation: cnt_clr coincident with match -> counter 0; counter forced to 32'hFFFF_FFFF plus match -> holds.
REQ-040 SHALL test reset mid-stream: i_reset with 2 items in flight -> no valid_out afterwards, counters 0, pattern 8'hEF.
